cycle_seq: RTL and testbench
============================

Name: cycle_seq

Overview:
- Parametrised one-hot phase sequencer for the multicycle picoMIPS datapath.
- Successor to the fixed 4-phase cycle counter. It adds:
  - configurable phase count;
  - stall;
  - early instruction termination (variable-length instructions);
  - binary phase index;
  - retired-instruction counter;
  - illegal-state detection and recovery.
- Sits beside the control decoder, which consumes phase/phase_idx and drives stall/last.

Parameters:
NUM_PHASES, 4, number of phases per full-length instruction (>=2)
MIN_PHASES, 2, earliest phase count at which `last` is honoured (1..NUM_PHASES)
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state on rising edge
nreset  input  1  asynchronous active-low reset
en  input  1  sequencer enable; when low, all state holds
stall  input  1  hold current phase (memory/IO wait)
last  input  1  current phase is the final phase of this instruction
phase  output  NUM_PHASES  one-hot current phase, bit 0 = fetch
phase_idx  output  $clog2(NUM_PHASES)  binary index of current phase
instr_end  output  1  current cycle completes an instruction (combinational)
retired  output  CNT_WIDTH  count of completed instructions
err  output  1  sticky: illegal (non-one-hot) phase state was detected

Behaviour:
- Reset (nreset low, asynchronous):
  - phase = 1 (bit 0), phase_idx = 0, retired = 0, err = 0.
  - Release is synchronous to the next edge; the first advance happens on the first clk edge with en=1, stall=0.
- adv = en & ~stall. If adv=0, phase, phase_idx and retired hold; stall dominates last.
- Term condition (evaluated only when adv=1):
  - term = (phase_idx == NUM_PHASES-1) | (last & (phase_idx >= MIN_PHASES-1)).
  - last below MIN_PHASES-1 is ignored and the sequencer advances normally.
- Next state on a clk edge with adv=1:
  - If term: phase <= 1 (bit 0) and retired <= retired + 1, wrapping modulo 2^CNT_WIDTH.
  - Otherwise: phase <= phase << 1.
- instr_end = adv & term; combinational from registered state and inputs.
- phase_idx is registered alongside phase, never decoded late; it must always equal the index of the set bit.
- Illegal state:
  - A phase value with zero bits or more than one bit set is illegal (SEU or forced).
  - On the next edge with en=1, regardless of stall: phase <= 1, phase_idx <= 0, err <= 1.
  - retired is not incremented and instr_end = 0 while illegal.
  - err stays set until nreset.
- Reset asserted mid-instruction: immediate return to reset values; a partial instruction is not counted.
- NUM_PHASES=4, no stall, last=0: sequence 0001→0010→0100→1000→0001; 1 retire per 4 cycles.

Decomposition:
- Shared package cycle_pkg holds:
  - phase index constants PH_FETCH=0, PH_DECODE=1, PH_EXEC=2, PH_WB=3;
  - the default NUM_PHASES;
  - typedef phase_t (logic [NUM_PHASES-1:0]);
  - a function onehot_valid(phase_t).
- The existing CYCLE_SIZE/CYCLE_WIDTH macros are superseded by this package.
- One natural sub-module: onehot_check (combinational validity + index encoder), reusable by other one-hot FSMs.

Test Plan:
- Reset, then 8 cycles en=1, stall=0, last=0 (NUM_PHASES=4) -> phase 1,2,4,8,1,2,4,8; instr_end high at cycles 4 and 8; retired=2.
- Early termination:
  - last=1 held while phase=2 (idx1) -> instr_end=1, next phase=1, retired increments.
  - last=1 at phase=1 (idx0, MIN_PHASES=2) -> ignored, next phase=2, no instr_end.
- Stall and enable hold: stall=1 for 3 cycles at phase=4 with last=1 -> phase stays 4, instr_end=0, retired unchanged; on stall release, wrap to 1 and retired+1. en=0 gives the same hold.
- Counter wrap (CNT_WIDTH=4): 16 instructions -> retired goes 15→0; NUM_PHASES=6 build with last=0 cycles all 6 phases in order.
- Illegal state:
  - Force phase=4'b0110 -> next edge phase=1, phase_idx=0, err=1, no retire; err persists over 20 normal cycles.
  - Assert nreset mid-instruction, asynchronously between edges -> outputs return to reset values immediately, err=0.

Source files
------------

// File: rtl/cycle_pkg.sv
// Shared definitions for the picoMIPS phase sequencer and other one-hot FSMs.
// Provides phase index names, the default phase count, the phase vector
// type and a one-hot validity helper.
package cycle_pkg;

   localparam int unsigned NUM_PHASES_DEF = 4;

   localparam int unsigned PH_FETCH  = 0;
   localparam int unsigned PH_DECODE = 1;
   localparam int unsigned PH_EXEC   = 2;
   localparam int unsigned PH_WB     = 3;

   typedef logic [NUM_PHASES_DEF-1:0] phase_t;

   // True when exactly one bit is set.
   function automatic logic onehot_valid(input phase_t p);
      return (p != '0) && ((p & (p - phase_t'(1))) == '0);
   endfunction

endpackage

// File: rtl/cycle_seq_onehot_check.sv
// Combinational one-hot validity check and binary index encoder.
// Ports:
//   vec     - one-hot vector under test
//   valid_c - high when exactly one bit of vec is set
//   idx_c   - binary index of the set bit (meaningful only when valid_c)
module cycle_seq_onehot_check
   import cycle_pkg::*;
#(
   parameter int unsigned W = NUM_PHASES_DEF
) (
   input  logic [W-1:0]         vec,
   output logic                 valid_c,
   output logic [$clog2(W)-1:0] idx_c
);

   localparam int unsigned IW = $clog2(W);

   assign valid_c = (vec != '0) && ((vec & (vec - W'(1))) == '0);

   // OR-reduction encoder: exact for one-hot input, no priority chain needed.
   always_comb begin
      idx_c = '0;
      for (int unsigned i = 0; i < W; i++) begin
         if (vec[i]) idx_c = idx_c | IW'(i);
      end
   end

endmodule

// File: rtl/cycle_seq.sv
// One-hot phase sequencer for the multicycle picoMIPS datapath.
// Ports:
//   clk, nreset - clock and asynchronous active-low reset
//   en          - enable; all state holds when low
//   stall       - hold current phase (dominates last)
//   last        - current phase ends this instruction (honoured from MIN_PHASES-1)
//   phase       - one-hot current phase, bit 0 = fetch
//   phase_idx   - binary index of current phase, registered with phase
//   instr_end   - combinational: this cycle completes an instruction
//   retired     - wrapping count of completed instructions
//   err         - sticky illegal-phase flag, cleared only by reset
module cycle_seq
   import cycle_pkg::*;
#(
   parameter int unsigned NUM_PHASES = NUM_PHASES_DEF,
   parameter int unsigned MIN_PHASES = 2,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          nreset,
   input  logic                          en,
   input  logic                          stall,
   input  logic                          last,
   output logic [NUM_PHASES-1:0]         phase,
   output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
   output logic                          instr_end,
   output logic [CNT_WIDTH-1:0]          retired,
   output logic                          err
);

   localparam int unsigned IW = $clog2(NUM_PHASES);

   logic          valid_c;
   logic [IW-1:0] enc_idx_c;
   logic          adv_c;
   logic          term_c;

   cycle_seq_onehot_check #(.W(NUM_PHASES)) u_check (
      .vec     (phase),
      .valid_c (valid_c),
      .idx_c   (enc_idx_c)
   );

   assign adv_c  = en & ~stall;
   assign term_c = (phase_idx == IW'(NUM_PHASES - 1))
                 | (last & (32'(phase_idx) >= (MIN_PHASES - 1)));
   // An illegal phase never completes an instruction.
   assign instr_end = adv_c & term_c & valid_c;

   // Phase register, index, retire counter and sticky error.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         phase     <= NUM_PHASES'(1);
         phase_idx <= '0;
         retired   <= '0;
         err       <= 1'b0;
      end else if (en) begin
         if (!valid_c) begin
            // Recovery ignores stall so a corrupted state cannot be held.
            phase     <= NUM_PHASES'(1);
            phase_idx <= '0;
            err       <= 1'b1;
         end else if (!stall) begin
            if (term_c) begin
               phase     <= NUM_PHASES'(1);
               phase_idx <= '0;
               retired   <= retired + CNT_WIDTH'(1);
            end else begin
               phase     <= phase << 1;
               // Derived from the encoded set bit so the index cannot drift.
               phase_idx <= IW'(enc_idx_c + IW'(1));
            end
         end
      end
   end

endmodule

// File: tb/tb_cycle_seq.sv
// Directed self-checking bench for cycle_seq: a 4-phase build, a 4-bit
// counter build and a 6-phase build share the same stimulus.
module tb_cycle_seq;

   logic clk;
   logic nreset;
   logic en;
   logic stall;
   logic last;

   logic [3:0]  phase;
   logic [1:0]  phase_idx;
   logic        instr_end;
   logic [15:0] retired;
   logic        err;

   logic [3:0]  phase_w;
   logic [1:0]  phase_idx_w;
   logic        instr_end_w;
   logic [3:0]  retired_w;
   logic        err_w;

   logic [5:0]  phase_6;
   logic [2:0]  phase_idx_6;
   logic        instr_end_6;
   logic [15:0] retired_6;
   logic        err_6;

   int pass_cnt = 0;
   int total    = 0;

   cycle_seq #(.NUM_PHASES(4), .MIN_PHASES(2), .CNT_WIDTH(16)) dut (
      .clk(clk), .nreset(nreset), .en(en), .stall(stall), .last(last),
      .phase(phase), .phase_idx(phase_idx), .instr_end(instr_end),
      .retired(retired), .err(err)
   );

   cycle_seq #(.NUM_PHASES(4), .MIN_PHASES(2), .CNT_WIDTH(4)) dut_w (
      .clk(clk), .nreset(nreset), .en(en), .stall(stall), .last(last),
      .phase(phase_w), .phase_idx(phase_idx_w), .instr_end(instr_end_w),
      .retired(retired_w), .err(err_w)
   );

   cycle_seq #(.NUM_PHASES(6), .MIN_PHASES(2), .CNT_WIDTH(16)) dut_6 (
      .clk(clk), .nreset(nreset), .en(en), .stall(stall), .last(0),
      .phase(phase_6), .phase_idx(phase_idx_6), .instr_end(instr_end_6),
      .retired(retired_6), .err(err_6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      nreset = 1'b0;
      en     = 1'b0;
      stall  = 1'b0;
      last   = 1'b0;
      #12;
      @(negedge clk);
      nreset = 1'b1;
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      en = 1'b0; stall = 1'b0; last = 1'b0;
      #7;
      total++;
      if (phase !== 4'b0001 || phase_idx !== 2'd0) $display("FAIL reset_phase: got %b/%0d, required 0001/0", phase, phase_idx);
      else pass_cnt++;
      total++;
      if (retired !== 16'd0 || err !== 1'b0 || instr_end !== 1'b0) $display("FAIL reset_regs: got retired=%0d err=%b ie=%b, required 0/0/0", retired, err, instr_end);
      else pass_cnt++;
      @(negedge clk);
      nreset = 1'b1;
      tick();
      total++;
      if (phase !== 4'b0001) $display("FAIL reset_en0_hold: got %b, required 0001", phase);
      else pass_cnt++;
   endtask

   task automatic test_basic();
      logic [3:0] exp_ph;
      en = 1'b1; stall = 1'b0; last = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_ph = 4'b0001 << (i % 4);
         #1;
         total++;
         if (phase !== exp_ph || phase_idx !== 2'(i % 4)) $display("FAIL basic_phase[%0d]: got %b/%0d, required %b/%0d", i, phase, phase_idx, exp_ph, i % 4);
         else pass_cnt++;
         total++;
         if (instr_end !== ((i % 4) == 3)) $display("FAIL basic_instr_end[%0d]: got %b, required %b", i, instr_end, (i % 4) == 3);
         else pass_cnt++;
         tick();
      end
      total++;
      if (retired !== 16'd2 || phase !== 4'b0001) $display("FAIL basic_retired: got %0d/%b, required 2/0001", retired, phase);
      else pass_cnt++;
   endtask

   task automatic test_early_term();
      last = 1'b1;
      #1;
      total++;
      if (instr_end !== 1'b0) $display("FAIL early_idx0_ie: got %b, required 0", instr_end);
      else pass_cnt++;
      tick();
      total++;
      if (phase !== 4'b0010 || retired !== 16'd2) $display("FAIL early_idx0_ignored: got %b/%0d, required 0010/2", phase, retired);
      else pass_cnt++;
      #1;
      total++;
      if (instr_end !== 1'b1) $display("FAIL early_idx1_ie: got %b, required 1", instr_end);
      else pass_cnt++;
      tick();
      total++;
      if (phase !== 4'b0001 || phase_idx !== 2'd0 || retired !== 16'd3) $display("FAIL early_idx1_term: got %b/%0d/%0d, required 0001/0/3", phase, phase_idx, retired);
      else pass_cnt++;
   endtask

   task automatic test_stall();
      last = 1'b0;
      tick(); tick();
      total++;
      if (phase !== 4'b0100) $display("FAIL stall_setup: got %b, required 0100", phase);
      else pass_cnt++;
      last = 1'b1; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (instr_end !== 1'b0) $display("FAIL stall_ie[%0d]: got %b, required 0", i, instr_end);
         else pass_cnt++;
         tick();
         total++;
         if (phase !== 4'b0100 || retired !== 16'd3) $display("FAIL stall_hold[%0d]: got %b/%0d, required 0100/3", i, phase, retired);
         else pass_cnt++;
      end
      stall = 1'b0;
      #1;
      total++;
      if (instr_end !== 1'b1) $display("FAIL stall_release_ie: got %b, required 1", instr_end);
      else pass_cnt++;
      tick();
      total++;
      if (phase !== 4'b0001 || retired !== 16'd4) $display("FAIL stall_release: got %b/%0d, required 0001/4", phase, retired);
      else pass_cnt++;
      // Enable-low hold at idx1 with last asserted.
      last = 1'b0;
      tick();
      last = 1'b1; en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (instr_end !== 1'b0) $display("FAIL en_ie[%0d]: got %b, required 0", i, instr_end);
         else pass_cnt++;
         tick();
         total++;
         if (phase !== 4'b0010 || retired !== 16'd4) $display("FAIL en_hold[%0d]: got %b/%0d, required 0010/4", i, phase, retired);
         else pass_cnt++;
      end
      en = 1'b1;
      tick();
      total++;
      if (phase !== 4'b0001 || retired !== 16'd5) $display("FAIL en_release: got %b/%0d, required 0001/5", phase, retired);
      else pass_cnt++;
      last = 1'b0;
   endtask

   task automatic test_wrap();
      apply_reset();
      en = 1'b1;
      for (int i = 0; i < 60; i++) tick();
      total++;
      if (retired_w !== 4'd15) $display("FAIL wrap_15: got %0d, required 15", retired_w);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) tick();
      total++;
      if (retired_w !== 4'd0 || phase_w !== 4'b0001) $display("FAIL wrap_0: got %0d/%b, required 0/0001", retired_w, phase_w);
      else pass_cnt++;
      total++;
      if (retired !== 16'd16) $display("FAIL wrap_wide: got %0d, required 16", retired);
      else pass_cnt++;
   endtask

   task automatic test_six();
      logic [5:0] exp_ph;
      apply_reset();
      en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         exp_ph = 6'b000001 << (i % 6);
         total++;
         if (phase_6 !== exp_ph || phase_idx_6 !== 3'(i % 6)) $display("FAIL six_phase[%0d]: got %b/%0d, required %b/%0d", i, phase_6, phase_idx_6, exp_ph, i % 6);
         else pass_cnt++;
         tick();
      end
      total++;
      if (retired_6 !== 16'd2) $display("FAIL six_retired: got %0d, required 2", retired_6);
      else pass_cnt++;
   endtask

   task automatic test_illegal();
      apply_reset();
      en = 1'b1;
      tick();
      force dut.phase = 4'b0110;
      #1;
      release dut.phase;
      stall = 1'b1;
      #1;
      total++;
      if (instr_end !== 1'b0) $display("FAIL illegal_ie: got %b, required 0", instr_end);
      else pass_cnt++;
      tick();
      total++;
      if (phase !== 4'b0001 || phase_idx !== 2'd0 || err !== 1'b1 || retired !== 16'd0) $display("FAIL illegal_recover: got %b/%0d err=%b ret=%0d, required 0001/0 err=1 ret=0", phase, phase_idx, err, retired);
      else pass_cnt++;
      stall = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      total++;
      if (err !== 1'b1 || retired !== 16'd5 || phase !== 4'b0001) $display("FAIL illegal_sticky: got err=%b ret=%0d ph=%b, required err=1 ret=5 ph=0001", err, retired, phase);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      tick(); tick();
      total++;
      if (phase !== 4'b0100) $display("FAIL async_setup: got %b, required 0100", phase);
      else pass_cnt++;
      #2;
      nreset = 1'b0;
      #1;
      total++;
      if (phase !== 4'b0001 || phase_idx !== 2'd0 || retired !== 16'd0 || err !== 1'b0) $display("FAIL async_reset: got %b/%0d ret=%0d err=%b, required 0001/0 ret=0 err=0", phase, phase_idx, retired, err);
      else pass_cnt++;
      @(negedge clk);
      nreset = 1'b1;
      tick();
      total++;
      if (phase !== 4'b0010 || retired !== 16'd0) $display("FAIL async_first_adv: got %b/%0d, required 0010/0", phase, retired);
      else pass_cnt++;
   endtask

   initial begin
      nreset = 1'b0;
      en = 1'b0; stall = 1'b0; last = 1'b0;
      test_reset();
      test_basic();
      test_early_term();
      test_stall();
      test_wrap();
      test_six();
      test_illegal();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
